// File: rtl/irom_pkg.sv
// Shared definitions for the instruction-ROM arbiter: requester count and ids.
package irom_pkg;

    localparam int NREQ = 2;

    typedef logic req_id_t;

    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_DEBUG = 1'b1;

endpackage

// File: rtl/irom_arbiter_rsp_slot.sv
// One-entry response buffer: holds a single ROM word until its requester pops it.
module rsp_slot #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              ready,
    output logic              valid,
    output logic [DWIDTH-1:0] data,
    output logic              free_or_pop
);

    logic              valid_reg;
    logic [DWIDTH-1:0] data_reg;

    // A write wins over a pop so a same-cycle refill keeps the slot full with new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (wr_en) begin
            valid_reg <= 1'b1;
            data_reg  <= wr_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid       = valid_reg;
    assign data        = data_reg;
    // Slot can accept the word of a read granted now: it is empty or drains this cycle.
    assign free_or_pop = ~valid_reg | ready;

endmodule

// File: rtl/irom_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction-ROM port between
// instruction fetch (requester 0) and debug/loader readback (requester 1).
module irom_arbiter
    import irom_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [AWIDTH-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_data,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [AWIDTH-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [AWIDTH-1:0] rom_addr,
    output logic              rom_ready,
    input  logic [DWIDTH-1:0] rom_dout,
    input  logic              rom_valid,
    output logic              proto_err
);

    logic              inflight_reg;
    req_id_t           owner_reg;
    req_id_t           last_grant_reg;
    logic              proto_err_reg;
    logic              mask_reg;

    logic [NREQ-1:0]   req_valid_vec;
    logic [NREQ-1:0]   rsp_ready_vec;
    logic [NREQ-1:0]   slot_free;
    logic [NREQ-1:0]   slot_wr;
    logic [NREQ-1:0]   slot_valid;
    logic [NREQ-1:0]   elig;
    logic [DWIDTH-1:0] slot_data [NREQ];

    logic              grant_valid;
    req_id_t           winner;

    assign req_valid_vec = {req1_valid, req0_valid};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    // Per-requester eligibility and response slot; the slot is written in the
    // data cycle when the tagged read belongs to it.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign elig[gi] = req_valid_vec[gi]
                            & ~(inflight_reg & (owner_reg == req_id_t'(gi)))
                            & slot_free[gi];
            assign slot_wr[gi] = inflight_reg & rom_valid & (owner_reg == req_id_t'(gi));

            rsp_slot #(
                .DWIDTH (DWIDTH)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_en       (slot_wr[gi]),
                .wr_data     (rom_dout),
                .ready       (rsp_ready_vec[gi]),
                .valid       (slot_valid[gi]),
                .data        (slot_data[gi]),
                .free_or_pop (slot_free[gi])
            );
        end
    endgenerate

    // Round-robin pick: a lone eligible requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant_valid = 1'b0;
        winner      = REQ_FETCH;
        if (rst_n) begin
            if (elig[0] && elig[1]) begin
                grant_valid = 1'b1;
                winner      = ~last_grant_reg;
            end else if (elig[0]) begin
                grant_valid = 1'b1;
                winner      = REQ_FETCH;
            end else if (elig[1]) begin
                grant_valid = 1'b1;
                winner      = REQ_DEBUG;
            end
        end
    end

    assign req0_ready = grant_valid & (winner == REQ_FETCH);
    assign req1_ready = grant_valid & (winner == REQ_DEBUG);
    assign rom_ready  = grant_valid;
    assign rom_addr   = (grant_valid && winner == REQ_DEBUG) ? req1_addr : req0_addr;

    // Tag pipeline and protocol checking; the mask hides stale ROM data right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_reg   <= 1'b0;
            owner_reg      <= REQ_FETCH;
            last_grant_reg <= REQ_DEBUG;
            proto_err_reg  <= 1'b0;
            mask_reg       <= 1'b1;
        end else begin
            mask_reg     <= 1'b0;
            inflight_reg <= grant_valid;
            if (grant_valid) begin
                owner_reg      <= winner;
                last_grant_reg <= winner;
            end
            // Stray data with nothing in flight, or a tagged read whose data never came.
            if ((rom_valid && !inflight_reg && !mask_reg) || (inflight_reg && !rom_valid)) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign rsp0_valid = slot_valid[0];
    assign rsp0_data  = slot_data[0];
    assign rsp1_valid = slot_valid[1];
    assign rsp1_data  = slot_data[1];
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_irom_arbiter.sv
// Directed bench for irom_arbiter: stimulus pushes expected ROM words into
// per-requester queues, a negedge monitor pops them as responses are consumed.
module tb_irom_arbiter;

    localparam int DWIDTH = 16;
    localparam int AWIDTH = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [AWIDTH-1:0] req0_addr, req1_addr;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DWIDTH-1:0] rsp0_data, rsp1_data;
    logic              rsp0_ready, rsp1_ready;
    logic [AWIDTH-1:0] rom_addr;
    logic              rom_ready;
    logic [DWIDTH-1:0] rom_dout;
    logic              rom_valid;
    logic              proto_err;
    logic              inject;

    int errors = 0;
    int checks = 0;
    logic [DWIDTH-1:0] q0 [$];
    logic [DWIDTH-1:0] q1 [$];

    always #5 clk = ~clk;

    irom_arbiter #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .rom_addr   (rom_addr),
        .rom_ready  (rom_ready),
        .rom_dout   (rom_dout),
        .rom_valid  (rom_valid),
        .proto_err  (proto_err)
    );

    // ROM contents: 0x005 holds 0x1234, every other word is 0xC000 | address.
    function automatic logic [DWIDTH-1:0] rom_word(input logic [AWIDTH-1:0] a);
        if (a == 12'h005) return 16'h1234;
        return {4'hC, a};
    endfunction

    // ROM wrapper model: data and valid one cycle after the strobe; inject forces a stray valid.
    always @(posedge clk) begin
        rom_valid <= rom_ready | inject;
        rom_dout  <= rom_word(rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every consumed response is compared against the head of its queue.
    always @(negedge clk) begin
        if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) begin
                chk("rsp0_unexpected_valid", 32'(rsp0_valid), 32'd0);
            end else begin
                $display("rsp0 pop data=%04h", rsp0_data);
                chk("rsp0_data", 32'(rsp0_data), 32'(q0.pop_front()));
            end
        end
        if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) begin
                chk("rsp1_unexpected_valid", 32'(rsp1_valid), 32'd0);
            end else begin
                $display("rsp1 pop data=%04h", rsp1_data);
                chk("rsp1_data", 32'(rsp1_data), 32'(q1.pop_front()));
            end
        end
    end

    // One arbitration cycle with hand-computed expected grants; accepted addresses advance.
    task automatic run_cycle(input bit e0, input bit e1, input bit push);
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("rom_ready", 32'(rom_ready), 32'(e0 | e1));
        if (e0) begin
            chk("rom_addr_req0", 32'(rom_addr), 32'(req0_addr));
            if (push) q0.push_back(rom_word(req0_addr));
            $display("grant req0 addr=%03h", req0_addr);
        end else if (e1) begin
            chk("rom_addr_req1", 32'(rom_addr), 32'(req1_addr));
            if (push) q1.push_back(rom_word(req1_addr));
            $display("grant req1 addr=%03h", req1_addr);
        end
        @(posedge clk);
        #1;
        if (e0) req0_addr = req0_addr + 1'b1;
        if (e1) req1_addr = req1_addr + 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; inject = 1'b0;
        req0_valid = 1'b1; req0_addr = 12'h005;
        req1_valid = 1'b0; req1_addr = 12'h800;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset hold with a pending request
        repeat (3) begin
            @(negedge clk);
            chk("rst_rom_ready", 32'(rom_ready), 32'd0);
            chk("rst_req0_ready", 32'(req0_ready), 32'd0);
            chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
            chk("rst_proto_err", 32'(proto_err), 32'd0);
        end
        chk("rst_rsp0_data", 32'(rsp0_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single read: first grant after reset goes to requester 0
        run_cycle(1'b1, 1'b0, 1'b1);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_rsp0_valid_T1", 32'(rsp0_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
            chk("single_rsp0_data", 32'(rsp0_data), 32'h1234);
        end
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        idle(1);
        @(negedge clk);
        chk("single_rsp0_popped", 32'(rsp0_valid), 32'd0);
        idle(1);

        // Contention: full-rate alternation, last grant was requester 0
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_addr = 12'h000; req1_addr = 12'h800;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) run_cycle(i % 2 == 1, i % 2 == 0, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(4);

        // Backpressure on requester 0; requester 1 keeps issuing every other cycle
        req0_addr = 12'h010; req1_addr = 12'h810;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b1);
        rsp0_ready = 1'b1;
        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(4);

        // Reset mid-operation: requester 1 read abandoned, stale data in the release cycle
        req1_addr = 12'h820; req1_valid = 1'b1;
        run_cycle(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0; inject = 1'b1;
        req0_valid = 1'b1; req0_addr = 12'h030;
        @(negedge clk);
        chk("midrst_rom_ready", 32'(rom_ready), 32'd0);
        chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
        chk("midrst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; inject = 1'b0;
        run_cycle(1'b1, 1'b0, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_rsp1_valid", 32'(rsp1_valid), 32'd0);
            chk("midrst_proto_err", 32'(proto_err), 32'd0);
        end
        idle(2);

        // Stray ROM data with no read in flight
        inject = 1'b1;
        @(negedge clk);
        chk("stray_proto_err_before", 32'(proto_err), 32'd0);
        @(posedge clk);
        #1;
        inject = 1'b0;
        @(negedge clk);
        chk("stray_proto_err_same", 32'(proto_err), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("stray_proto_err_sticky", 32'(proto_err), 32'd1);
            chk("stray_rsp0_valid", 32'(rsp0_valid), 32'd0);
            chk("stray_rsp1_valid", 32'(rsp1_valid), 32'd0);
        end

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
